// File: rtl/if_stage_if.sv
// Instruction-memory request/response bus between the fetch stage and imem.
// At most one request outstanding; rvalid returns the word some cycles after acceptance.
interface if_stage_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;

  modport master (output imem_req, imem_addr, input imem_ready, imem_rvalid, imem_rdata);
  modport slave  (input imem_req, imem_addr, output imem_ready, imem_rvalid, imem_rdata);
endinterface

// File: rtl/if_stage.sv
// Instruction fetch stage: one outstanding imem request, an output register
// towards decode and a 1-entry skid for a response that lands while decode stalls.
module if_stage #(
  parameter logic [31:0] NOP_INSTR = 32'h00000013
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] pc_in,
  output logic        pc_advance,
  if_stage_if.master  imem,
  input  logic        stall,
  input  logic        flush,
  output logic        instr_valid,
  output logic [31:0] instr,
  output logic [31:0] instr_pc
);

  typedef enum logic [1:0] {IDLE, REQ, WAIT, FULL} state_t;

  state_t      state, state_n;
  logic        drop;
  logic [31:0] req_pc, out_instr, skid_instr, skid_pc;
  logic        consume, load_out, load_skid, move_skid;

  assign consume        = instr_valid && !stall;
  assign imem.imem_req  = (state == REQ) && !flush && !reset;
  assign imem.imem_addr = {pc_in[31:2], 2'b00};
  assign pc_advance     = imem.imem_req && imem.imem_ready;
  assign instr          = instr_valid ? out_instr : NOP_INSTR;

  always_comb begin
    state_n   = state;
    load_out  = 1'b0;
    load_skid = 1'b0;
    move_skid = 1'b0;
    case (state)
      IDLE: state_n = REQ;
      REQ:  if (pc_advance) state_n = WAIT;
      WAIT: if (imem.imem_rvalid) begin
        // a response under flush or after a flush in WAIT is discarded
        if (flush || drop)
          state_n = REQ;
        else if (consume || !instr_valid) begin
          load_out = 1'b1;
          state_n  = REQ;
        end else begin
          load_skid = 1'b1;
          state_n   = FULL;
        end
      end
      FULL: if (flush) state_n = REQ;
            else if (consume) begin
              move_skid = 1'b1;
              state_n   = REQ;
            end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_n;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      instr_valid <= 1'b0;
      out_instr   <= NOP_INSTR;
      instr_pc    <= '0;
      drop        <= 1'b0;
      req_pc      <= '0;
      skid_instr  <= '0;
      skid_pc     <= '0;
    end else begin
      if (pc_advance) req_pc <= pc_in;
      if (flush) begin
        instr_valid <= 1'b0;
        // remember to swallow the in-flight word unless it is arriving right now
        drop        <= (state == WAIT) && !imem.imem_rvalid;
      end else begin
        if (state == WAIT && imem.imem_rvalid) drop <= 1'b0;
        if (load_out) begin
          instr_valid <= 1'b1;
          out_instr   <= imem.imem_rdata;
          instr_pc    <= req_pc;
        end else if (move_skid) begin
          instr_valid <= 1'b1;
          out_instr   <= skid_instr;
          instr_pc    <= skid_pc;
        end else if (consume) begin
          instr_valid <= 1'b0;
        end
        if (load_skid) begin
          skid_instr <= imem.imem_rdata;
          skid_pc    <= req_pc;
        end
      end
    end
  end

endmodule

// File: tb/tb_if_stage.sv
// Self-checking bench for if_stage: directed scenarios, then random traffic
// scored against an in-order fetch-stream model with a latency-queue memory.
module tb_if_stage;
  localparam logic [31:0] NOP = 32'h00000013;

  logic        clk = 1'b0;
  logic        reset, stall, flush;
  logic [31:0] pc_in;
  logic        pc_advance, instr_valid;
  logic [31:0] instr, instr_pc;
  int          n_chk = 0, n_fail = 0;

  if_stage_if imem ();

  if_stage #(.NOP_INSTR(NOP)) dut (
    .clk(clk), .reset(reset), .pc_in(pc_in), .pc_advance(pc_advance), .imem(imem),
    .stall(stall), .flush(flush), .instr_valid(instr_valid), .instr(instr), .instr_pc(instr_pc)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] mword(input logic [31:0] a);
    return (a * 32'h9E3779B1) ^ 32'hA5A50013;
  endfunction

  // drive one cycle's inputs at negedge, leave 1 time unit for combinational outputs
  task automatic drv(input logic r, input logic st, input logic fl, input logic [31:0] pc,
                     input logic rdy, input logic rv, input logic [31:0] rd);
    @(negedge clk);
    reset = r; stall = st; flush = fl; pc_in = pc;
    imem.imem_ready = rdy; imem.imem_rvalid = rv; imem.imem_rdata = rd;
    #1;
  endtask

  task automatic run_random(input int n);
    logic [31:0] pc;
    logic [31:0] exp_q[$];
    logic [31:0] maddr_q[$];
    int          due_q[$];
    logic        hold;
    logic [31:0] h_instr, h_pc;
    int          consumed;
    logic        rv;
    pc = 32'h100; hold = 1'b0; consumed = 0; h_instr = '0; h_pc = '0;
    for (int c = 0; c < n; c++) begin
      rv = (due_q.size() > 0) && (due_q[0] == c);
      drv(1'b0, $urandom_range(0, 3) == 0, $urandom_range(0, 19) == 0, pc,
          $urandom_range(0, 2) != 0, rv, rv ? mword(maddr_q[0]) : $urandom);
      if (hold) begin
        check("hold_valid", {31'b0, instr_valid}, 32'd1);
        check("hold_instr", instr, h_instr);
        check("hold_pc", instr_pc, h_pc);
      end
      check("pc_adv", {31'b0, pc_advance}, {31'b0, imem.imem_req & imem.imem_ready});
      if (flush) check("flush_noreq", {31'b0, imem.imem_req}, 32'd0);
      if (imem.imem_req) check("addr", imem.imem_addr, {pc[31:2], 2'b00});
      if (!instr_valid) check("nop", instr, NOP);
      if (instr_valid && !stall && !flush) begin
        if (exp_q.size() == 0) check("underflow", 32'd1, 32'd0);
        else begin
          check("stream_instr", instr, mword({exp_q[0][31:2], 2'b00}));
          check("stream_pc", instr_pc, exp_q[0]);
          void'(exp_q.pop_front());
          consumed++;
        end
      end
      hold = instr_valid && stall && !flush;
      h_instr = instr; h_pc = instr_pc;
      if (rv) begin
        void'(due_q.pop_front());
        void'(maddr_q.pop_front());
      end
      if (pc_advance) begin
        due_q.push_back(c + $urandom_range(1, 3));
        maddr_q.push_back(imem.imem_addr);
        exp_q.push_back(pc);
      end
      if (flush) begin
        exp_q.delete();
        pc = $urandom & 32'h0000FFFE;
      end else if (pc_advance) pc = pc + 32'd4;
    end
    check("consumed_some", {31'b0, consumed > 50}, 32'd1);
  endtask

  initial begin
    reset = 1'b1; stall = 1'b0; flush = 1'b0; pc_in = '0;
    imem.imem_ready = 1'b0; imem.imem_rvalid = 1'b0; imem.imem_rdata = '0;
    drv(1, 0, 0, 0, 1, 0, 0);
    check("rst_req", {31'b0, imem.imem_req}, 32'd0);
    check("rst_adv", {31'b0, pc_advance}, 32'd0);
    // cycle 0: IDLE after reset
    drv(0, 0, 0, 0, 1, 0, 0);
    check("c0_valid", {31'b0, instr_valid}, 32'd0);
    check("c0_instr", instr, NOP);
    check("c0_pc", instr_pc, 32'd0);
    check("c0_req", {31'b0, imem.imem_req}, 32'd0);
    // cycle 1: request at pc 0
    drv(0, 0, 0, 0, 1, 0, 0);
    check("c1_req", {31'b0, imem.imem_req}, 32'd1);
    check("c1_adv", {31'b0, pc_advance}, 32'd1);
    check("c1_addr", imem.imem_addr, 32'd0);
    drv(0, 1, 0, 0, 0, 1, 32'h1111_0001);
    check("c2_wait_noreq", {31'b0, imem.imem_req}, 32'd0);
    // memory not ready for 3 cycles, decode stalled with the first word held
    for (int i = 0; i < 3; i++) begin
      drv(0, 1, 0, 32'h8, 0, 0, 0);
      check("nr_req", {31'b0, imem.imem_req}, 32'd1);
      check("nr_adv", {31'b0, pc_advance}, 32'd0);
      check("nr_addr", imem.imem_addr, 32'h8);
      check("nr_instr", instr, 32'h1111_0001);
      check("nr_pc", instr_pc, 32'd0);
      check("nr_valid", {31'b0, instr_valid}, 32'd1);
    end
    drv(0, 1, 0, 32'h8, 1, 0, 0);
    check("acc8_adv", {31'b0, pc_advance}, 32'd1);
    drv(0, 1, 0, 32'hC, 1, 1, 32'h2222_0002);
    for (int i = 0; i < 2; i++) begin
      drv(0, 1, 0, 32'hC, 1, 0, 0);
      check("full_noreq", {31'b0, imem.imem_req}, 32'd0);
      check("full_instr", instr, 32'h1111_0001);
    end
    drv(0, 0, 0, 32'hC, 0, 0, 0);
    check("rel_instr", instr, 32'h1111_0001);
    drv(0, 0, 0, 32'h20, 1, 0, 0);
    check("skid_valid", {31'b0, instr_valid}, 32'd1);
    check("skid_instr", instr, 32'h2222_0002);
    check("skid_pc", instr_pc, 32'h8);
    check("skid_req", {31'b0, pc_advance}, 32'd1);
    // flush in WAIT, response two cycles later must be dropped
    drv(0, 0, 1, 32'h40, 0, 0, 0);
    check("fl_noreq", {31'b0, imem.imem_req}, 32'd0);
    drv(0, 0, 0, 32'h40, 0, 0, 0);
    check("fl_valid", {31'b0, instr_valid}, 32'd0);
    drv(0, 0, 0, 32'h40, 0, 1, 32'h3333_0003);
    check("drop_noreq", {31'b0, imem.imem_req}, 32'd0);
    drv(0, 0, 0, 32'h40, 1, 0, 0);
    check("drop_valid", {31'b0, instr_valid}, 32'd0);
    check("drop_nextaddr", imem.imem_addr, 32'h40);
    check("drop_adv", {31'b0, pc_advance}, 32'd1);
    // flush coincident with rvalid
    drv(0, 0, 1, 32'h44, 0, 1, 32'h4444_0004);
    drv(0, 0, 0, 32'h44, 0, 0, 0);
    check("flrv_valid", {31'b0, instr_valid}, 32'd0);
    check("flrv_instr", instr, NOP);
    check("flrv_req", {31'b0, imem.imem_req}, 32'd1);
    drv(0, 0, 0, 32'h44, 0, 1, 32'h5555_0005);
    drv(0, 0, 0, 32'h48, 1, 0, 0);
    check("stray_req_valid", {31'b0, instr_valid}, 32'd0);
    check("stray_req_instr", instr, NOP);
    // reset in WAIT, then a stray response
    drv(1, 0, 0, 32'h48, 1, 0, 0);
    check("rstw_req", {31'b0, imem.imem_req}, 32'd0);
    check("rstw_adv", {31'b0, pc_advance}, 32'd0);
    drv(0, 0, 0, 32'h48, 0, 1, 32'h6666_0006);
    drv(0, 0, 0, 32'h48, 0, 1, 32'h6666_0006);
    check("rstw_reqagain", {31'b0, imem.imem_req}, 32'd1);
    drv(0, 0, 0, 32'h106, 1, 0, 0);
    check("rstw_valid", {31'b0, instr_valid}, 32'd0);
    check("rstw_instr", instr, NOP);
    check("rstw_pc", instr_pc, 32'd0);
    // unaligned pc
    check("ua_addr", imem.imem_addr, 32'h104);
    check("ua_adv", {31'b0, pc_advance}, 32'd1);
    drv(0, 0, 0, 32'h10A, 0, 1, 32'h7777_0007);
    drv(0, 0, 0, 32'h10A, 0, 0, 0);
    check("ua_valid", {31'b0, instr_valid}, 32'd1);
    check("ua_instr", instr, 32'h7777_0007);
    check("ua_pc", instr_pc, 32'h106);
    // random traffic from a clean reset
    drv(1, 0, 0, 0, 0, 0, 0);
    run_random(3000);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
